// File: rtl/row_input_ctrl.sv
// row_input_ctrl: assembles BW-bit host words into LANES*DW-bit vectors,
// buffers up to two complete vectors, and issues them into a systolic row
// through a per-lane skew pipeline (lane k delayed by k extra cycles).
module row_input_ctrl #(
    parameter int LANES = 8,
    parameter int DW    = 8,
    parameter int BW    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BW-1:0]         in_w,
    input  logic                  wvalid,
    output logic                  wready,
    input  logic                  en,
    output logic [LANES*DW-1:0]   out_r,
    output logic [LANES-1:0]      out_v,
    output logic                  busy
);

    localparam int VW  = LANES * DW;
    localparam int WPV = VW / BW;
    localparam int WCW = (WPV > 1) ? $clog2(WPV) : 1;
    localparam logic [WCW-1:0] WLAST = WCW'(WPV - 1);

    logic [WCW-1:0]   wcnt_r;
    logic [VW-1:0]    asm_r;
    logic [VW-1:0]    fifo_mem_r [0:1];
    logic             rd_ptr_r;
    logic             wr_ptr_r;
    logic [1:0]       cnt_r;

    logic             accept_s;
    logic             push_s;
    logic             pop_s;
    logic [VW-1:0]    vec_s;
    logic [VW-1:0]    head_s;
    logic [LANES-1:0] lane_busy_s;

    // A completing word is refused whenever the FIFO is full, even if a pop
    // happens on the same edge; this keeps wready independent of en.
    assign wready   = (wcnt_r != WLAST) || (cnt_r < 2'd2);
    assign accept_s = wvalid && wready;
    assign push_s   = accept_s && (wcnt_r == WLAST);
    assign pop_s    = en && (cnt_r != 2'd0);
    assign head_s   = fifo_mem_r[rd_ptr_r];
    assign busy     = (wcnt_r != '0) || (cnt_r != 2'd0) || (|lane_busy_s);

    // Merge the incoming word into its slot of the partially assembled vector.
    always_comb begin
        vec_s = asm_r;
        vec_s[int'(wcnt_r) * BW +: BW] = in_w;
    end

    // Word counter and assembly buffer; stale slots are always overwritten before the next push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt_r <= '0;
            asm_r  <= '0;
        end else if (accept_s) begin
            asm_r  <= vec_s;
            wcnt_r <= (wcnt_r == WLAST) ? '0 : wcnt_r + WCW'(1);
        end else begin
            wcnt_r <= wcnt_r;
            asm_r  <= asm_r;
        end
    end

    // Two-entry vector FIFO; push and pop at count 1 touch different entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_mem_r[0] <= '0;
            fifo_mem_r[1] <= '0;
            rd_ptr_r      <= 1'b0;
            wr_ptr_r      <= 1'b0;
            cnt_r         <= 2'd0;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= vec_s;
                wr_ptr_r             <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + 2'd1;
                2'b01:   cnt_r <= cnt_r - 2'd1;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Skew pipeline: lane k owns k+1 stages and its last stage is the output register.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [DW-1:0] d_r [0:k];
        logic [k:0]    v_r;

        // Advance this lane only when the array advances; bubbles carry zero data.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int j = 0; j <= k; j++) begin
                    d_r[j] <= '0;
                end
                v_r <= '0;
            end else if (en) begin
                d_r[0] <= pop_s ? head_s[k*DW +: DW] : '0;
                v_r[0] <= pop_s;
                for (int j = 1; j <= k; j++) begin
                    d_r[j] <= d_r[j-1];
                    v_r[j] <= v_r[j-1];
                end
            end else begin
                v_r <= v_r;
            end
        end

        assign out_r[k*DW +: DW] = d_r[k];
        assign out_v[k]          = v_r[k];
        assign lane_busy_s[k]    = |v_r;
    end

endmodule
